// File: rtl/oven_controller.sv
// Oven cook-cycle controller: validates a start request, preheats to the
// latched target, bakes for a tick-counted duration, then waits for ack.
// Optional feature macro: OVEN_TIMEOUT_EN adds a preheat timeout into FAULT.
module oven_controller #(
    parameter int unsigned TICK_DIV      = 50,
    parameter int unsigned MIN_TEMP      = 150,
    parameter int unsigned MAX_TEMP      = 500,
    parameter int unsigned PREHEAT_LIMIT = 600
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic        cancel,
    input  logic        ack,
    input  logic [9:0]  targetTemp,
    input  logic [11:0] bakeTime,
    input  logic [9:0]  currentTemp,
    input  logic        preheated,
    output logic        heat,
    output logic        tempInputDone,
    output logic [2:0]  state,
    output logic [11:0] remaining,
    output logic        done,
    output logic        error
);

    localparam int unsigned TW = 10;
    localparam int unsigned BW = 12;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Parameter sanity checks at elaboration
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("oven_controller: TICK_DIV must be >= 2");
    end
    if (PREHEAT_LIMIT < 1) begin : g_bad_preheat_limit
        $error("oven_controller: PREHEAT_LIMIT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREHEAT = 3'd1,
        S_BAKE    = 3'd2,
        S_DONE    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_target;
    logic [BW-1:0]   r_bake;
    logic [BW-1:0]   r_remaining;
    logic [PW-1:0]   r_presc;
    logic            r_heat;
    logic            r_tid;
    logic            r_done;
    logic            r_error;

`ifdef OVEN_TIMEOUT_EN
    localparam int unsigned LW = (PREHEAT_LIMIT > 1) ? $clog2(PREHEAT_LIMIT) : 1;
    logic [LW-1:0]   r_tmo;
    logic            w_tmo_last;
    assign w_tmo_last = (r_tmo == LW'(PREHEAT_LIMIT - 1));
`endif

    logic w_start_ok;
    logic w_tick;
    logic w_below;
    logic w_leave;

    assign w_start_ok = (targetTemp >= TW'(MIN_TEMP)) && (targetTemp <= TW'(MAX_TEMP))
                        && (bakeTime != '0);
    assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
    assign w_below    = (currentTemp < r_target);
    // Cancel from any active state, or ack from a terminal state, returns to IDLE
    assign w_leave    = (r_state != S_IDLE) &&
                        (cancel || (((r_state == S_DONE) || (r_state == S_FAULT)) && ack));

    // Controller state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_bake      <= '0;
            r_remaining <= '0;
            r_presc     <= '0;
            r_heat      <= 1'b0;
            r_tid       <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef OVEN_TIMEOUT_EN
            r_tmo       <= '0;
`endif
        end else begin
            r_error <= 1'b0;
            if (w_leave) begin
                r_state     <= S_IDLE;
                r_remaining <= '0;
                r_presc     <= '0;
                r_heat      <= 1'b0;
                r_tid       <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !cancel) begin
                            if (w_start_ok) begin
                                r_target <= targetTemp;
                                r_bake   <= bakeTime;
                                r_presc  <= '0;
                                r_heat   <= (currentTemp < targetTemp);
                                r_tid    <= 1'b1;
                                r_state  <= S_PREHEAT;
`ifdef OVEN_TIMEOUT_EN
                                r_tmo    <= '0;
`endif
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    S_PREHEAT: begin
                        r_heat <= w_below;
                        if (preheated) begin
                            r_remaining <= r_bake;
                            r_presc     <= '0;
                            r_state     <= S_BAKE;
                        end
`ifdef OVEN_TIMEOUT_EN
                        else if (w_tick) begin
                            r_presc <= '0;
                            if (w_tmo_last) begin
                                r_heat  <= 1'b0;
                                r_state <= S_FAULT;
                            end else begin
                                r_tmo <= r_tmo + LW'(1);
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
`endif
                    end
                    S_BAKE: begin
                        if (w_tick) begin
                            r_presc <= '0;
                            if (r_remaining == BW'(1)) begin
                                r_remaining <= '0;
                                r_heat      <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_remaining <= r_remaining - BW'(1);
                                r_heat      <= w_below;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                            r_heat  <= w_below;
                        end
                    end
                    S_DONE, S_FAULT: begin
                        r_heat <= 1'b0;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_remaining <= '0;
                        r_heat      <= 1'b0;
                        r_tid       <= 1'b0;
                        r_done      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state         = r_state;
    assign heat          = r_heat;
    assign tempInputDone = r_tid;
    assign remaining     = r_remaining;
    assign done          = r_done;
    assign error         = r_error;

endmodule

// File: tb/tb_oven_controller.sv
// Self-checking bench for oven_controller: directed scenarios followed by
// randomized stimulus, all checked against a cycle-count based reference model.
module tb_oven_controller;

    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned MIN_TEMP      = 150;
    localparam int unsigned MAX_TEMP      = 500;
    localparam int unsigned PREHEAT_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rstN, start, cancel, ack, preheated;
    logic [9:0]  targetTemp, currentTemp;
    logic [11:0] bakeTime;
    logic        heat, tempInputDone, done, error;
    logic [2:0]  state;
    logic [11:0] remaining;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: phase code plus cycles spent in the current phase
    int unsigned m_state = 0;
    int unsigned m_tgt   = 0;
    int unsigned m_bt    = 0;
    int unsigned m_cyc   = 0;
    bit          m_heat  = 1'b0;
    bit          m_err   = 1'b0;

    always #5 clk = ~clk;

    oven_controller #(
        .TICK_DIV      (TICK_DIV),
        .MIN_TEMP      (MIN_TEMP),
        .MAX_TEMP      (MAX_TEMP),
        .PREHEAT_LIMIT (PREHEAT_LIMIT)
    ) u_dut (
        .clk           (clk),
        .rstN          (rstN),
        .start         (start),
        .cancel        (cancel),
        .ack           (ack),
        .targetTemp    (targetTemp),
        .bakeTime      (bakeTime),
        .currentTemp   (currentTemp),
        .preheated     (preheated),
        .heat          (heat),
        .tempInputDone (tempInputDone),
        .state         (state),
        .remaining     (remaining),
        .done          (done),
        .error         (error)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented before it
    task automatic model_step();
        m_err = 1'b0;
        if (!rstN) begin
            m_state = 0; m_tgt = 0; m_bt = 0; m_cyc = 0; m_heat = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    if (start && !cancel) begin
                        if (targetTemp >= MIN_TEMP && targetTemp <= MAX_TEMP && bakeTime != 0) begin
                            m_tgt = targetTemp; m_bt = bakeTime; m_cyc = 0; m_state = 1;
                            m_heat = (currentTemp < m_tgt);
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
                1: begin
                    if (cancel) begin
                        m_state = 0; m_heat = 1'b0;
                    end else if (preheated) begin
                        m_state = 2; m_cyc = 0; m_heat = (currentTemp < m_tgt);
                    end else begin
                        m_cyc++;
                        m_heat = (currentTemp < m_tgt);
`ifdef OVEN_TIMEOUT_EN
                        if (m_cyc >= PREHEAT_LIMIT * TICK_DIV) begin
                            m_state = 4; m_heat = 1'b0;
                        end
`endif
                    end
                end
                2: begin
                    if (cancel) begin
                        m_state = 0; m_heat = 1'b0;
                    end else begin
                        m_cyc++;
                        if (m_cyc / TICK_DIV >= m_bt) begin
                            m_state = 3; m_heat = 1'b0;
                        end else begin
                            m_heat = (currentTemp < m_tgt);
                        end
                    end
                end
                default: begin
                    m_heat = 1'b0;
                    if (cancel || ack) m_state = 0;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        int unsigned exp_rem;
        exp_rem = (m_state == 2) ? (m_bt - m_cyc / TICK_DIV) : 0;
        check("state", state, m_state);
        check("heat", heat, m_heat);
        check("tempInputDone", tempInputDone, (m_state != 0) ? 1 : 0);
        check("remaining", remaining, exp_rem);
        check("done", done, (m_state == 3) ? 1 : 0);
        check("error", error, m_err);
    endtask

    // One clock: drive on the falling edge, model on the rising edge, sample 1ns later
    task automatic run(input logic rn, input logic st, input logic cn, input logic ak,
                       input logic ph, input logic [9:0] tt, input logic [9:0] ct,
                       input logic [11:0] bt);
        @(negedge clk);
        rstN = rn; start = st; cancel = cn; ack = ak; preheated = ph;
        targetTemp = tt; currentTemp = ct; bakeTime = bt;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_n(input int n, input logic ph, input logic [9:0] ct);
        for (int i = 0; i < n; i++) run(1'b1, 1'b0, 1'b0, 1'b0, ph, 10'd0, ct, 12'd0);
    endtask

    initial begin
        rstN = 1'b0; start = 1'b0; cancel = 1'b0; ack = 1'b0; preheated = 1'b0;
        targetTemp = '0; currentTemp = '0; bakeTime = '0;

        // Reset state
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0);
        check("reset_state", state, 0);
        check("reset_tid", tempInputDone, 0);

        // Normal cook: 3 ticks of 4 cycles each
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd350, 10'd0, 12'd3);
        check("preheat_enter", state, 1);
        check("preheat_heat", heat, 1);
        wait_n(9, 1'b0, 10'd0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 12'd0);
        check("bake_enter_state", state, 2);
        check("bake_enter_rem", remaining, 3);
        wait_n(11, 1'b0, 10'd0);
        check("bake_11_state", state, 2);
        check("bake_11_rem", remaining, 1);
        wait_n(1, 1'b0, 10'd0);
        check("done_at_12_state", state, 3);
        check("done_at_12_flag", done, 1);
        check("done_heat", heat, 0);
        wait_n(2, 1'b0, 10'd0);
        check("done_hold", state, 3);
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 12'd0);
        check("done_ack", state, 0);

        // Rejected starts and range boundaries
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd0, 12'd3);
        check("reject_low_err", error, 1);
        check("reject_low_state", state, 0);
        wait_n(1, 1'b0, 10'd0);
        check("error_one_cycle", error, 0);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd300, 10'd0, 12'd0);
        check("reject_zero_time", error, 1);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd501, 10'd0, 12'd3);
        check("reject_high", error, 1);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd149, 10'd0, 12'd3);
        check("reject_149", error, 1);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd500, 10'd0, 12'd3);
        check("accept_500", state, 1);
        run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0);
        check("cancel_preheat", state, 0);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd150, 10'd0, 12'd3);
        check("accept_150", state, 1);
        run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0);

        // Start with cancel in IDLE does nothing
        run(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd300, 10'd0, 12'd3);
        check("start_cancel_err", error, 0);
        check("start_cancel_state", state, 0);

        // Cancel mid-bake
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd350, 10'd0, 12'd3);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 12'd0);
        wait_n(4, 1'b0, 10'd0);
        check("pre_cancel_rem", remaining, 2);
        run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0);
        check("cancel_state", state, 0);
        check("cancel_heat", heat, 0);
        check("cancel_rem", remaining, 0);

        // Start during BAKE must not change the latched target
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd350, 10'd0, 12'd20);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 12'd0);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd200, 10'd300, 12'd5);
        check("bake_start_ignored", state, 2);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd250, 12'd0);
        check("heat_keeps_target", heat, 1);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd350, 12'd0);
        check("heat_at_target", heat, 0);

        // Reset mid-bake
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0);
        check("midrst_state", state, 0);
        check("midrst_heat", heat, 0);
        check("midrst_tid", tempInputDone, 0);
        check("midrst_rem", remaining, 0);

`ifdef OVEN_TIMEOUT_EN
        // Preheat timeout after PREHEAT_LIMIT ticks
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd350, 10'd0, 12'd3);
        wait_n(31, 1'b0, 10'd0);
        check("tmo_31_state", state, 1);
        wait_n(1, 1'b0, 10'd0);
        check("tmo_fault", state, 4);
        check("tmo_heat", heat, 0);
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 12'd0);
        check("fault_ack", state, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [9:0]  tt;
            logic [11:0] bt;
            case ($urandom_range(0, 5))
                0:       tt = 10'($urandom_range(0, 1023));
                1:       tt = ($urandom_range(0, 1) != 0) ? 10'd149 : 10'd501;
                2:       tt = ($urandom_range(0, 1) != 0) ? 10'd150 : 10'd500;
                default: tt = 10'($urandom_range(MIN_TEMP, MAX_TEMP));
            endcase
            bt = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 6));
            run(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0), tt, 10'($urandom_range(0, 1023)), bt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
